// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the sky130 SRAM BIST engine.
//   state_e      : BIST controller state (IDLE, RUN, DRAIN, DONE)
//   elem_t, E0-E5: March element index
//   elem_info()  : per-element direction, op count, read/write data bits
package sram_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [2:0] elem_t;

    localparam elem_t E0 = 3'd0;
    localparam elem_t E1 = 3'd1;
    localparam elem_t E2 = 3'd2;
    localparam elem_t E3 = 3'd3;
    localparam elem_t E4 = 3'd4;
    localparam elem_t E5 = 3'd5;

    // down     : address sweep runs DEPTH-1 .. 0
    // two_ops  : element is a read followed by a write at each address
    // has_read : element contains a read (single-op elements without one are writes)
    // rd_bit   : expected data bit for the read
    // wr_bit   : data bit written
    typedef struct packed {
        logic down;
        logic two_ops;
        logic has_read;
        logic rd_bit;
        logic wr_bit;
    } elem_info_t;

    function automatic elem_info_t elem_info(input elem_t e);
        elem_info_t i;
        i = '0;
        case (e)
            E0:      i = 5'b0_0_0_0_0; // up   : w0
            E1:      i = 5'b0_1_1_0_1; // up   : r0, w1
            E2:      i = 5'b0_1_1_1_0; // up   : r1, w0
            E3:      i = 5'b1_1_1_0_1; // down : r0, w1
            E4:      i = 5'b1_1_1_1_0; // down : r1, w0
            E5:      i = 5'b0_0_1_0_0; // up   : r0
            default: i = '0;
        endcase
        return i;
    endfunction

endpackage

// File: rtl/sram_bist_cmp_pipe.sv
// Read-data compare pipeline. Each read pushes {valid, addr, expected} into a
// READ_LATENCY-deep delay line so the entry reaches the output in the same
// cycle the wrapper presents the matching dout.
//   clock, reset     : clock and synchronous active-high reset
//   push_valid       : a read is being issued this cycle
//   push_addr        : address of that read
//   push_data        : data that read must return
//   dout             : wrapper read data
//   miscompare       : valid entry at the output whose data does not match
//   miscompare_addr  : address of the entry at the output
module sram_bist_cmp_pipe #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_valid,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  miscompare,
    output logic [ADDR_WIDTH-1:0] miscompare_addr
);

    logic                  valid_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_q  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] exp_q   [READ_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                exp_q[i]   <= '0;
            end
        end else begin
            valid_q[0] <= push_valid;
            addr_q[0]  <= push_addr;
            exp_q[0]   <= push_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
                exp_q[i]   <= exp_q[i-1];
            end
        end
    end

    assign miscompare      = valid_q[READ_LATENCY-1] && (dout != exp_q[READ_LATENCY-1]);
    assign miscompare_addr = addr_q[READ_LATENCY-1];

endmodule

// File: rtl/sram_bist_sky130.sv
// March C- built-in self-test engine for one sky130 SRAM wrapper instance.
// Drives the wrapper's we/wmask/addr/din combinationally from registered state
// (the wrapper registers its inputs) and checks dout through a delay line.
//   clock, reset        : shared clock, synchronous active-high reset
//   start               : one-cycle request, accepted only in IDLE or DONE
//   busy / done / pass  : run status; pass is meaningful while done is high
//   fail_addr           : address of the first miscompare of the last test
//   fail_count          : saturating count of miscompared reads
//   sram_we/wmask/addr/din, sram_dout : wrapper interface
//   state_dbg           : current controller state
//
// Handshake: start has no ready. A start pulse is taken when the controller is
// in IDLE or DONE (busy low) and ignored otherwise; busy stays high from the
// cycle after acceptance until the compare pipeline has drained, and done then
// holds with the results until the next accepted start or reset.
module sram_bist_sky130
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int WMASK_WIDTH    = 4,
    parameter int READ_LATENCY   = 2,
    parameter int FAIL_CNT_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ADDR_WIDTH-1:0]     fail_addr,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic                      sram_we,
    output logic [WMASK_WIDTH-1:0]    sram_wmask,
    output logic [ADDR_WIDTH-1:0]     sram_addr,
    output logic [DATA_WIDTH-1:0]     sram_din,
    input  logic [DATA_WIDTH-1:0]     sram_dout,
    output state_e                    state_dbg
);

    localparam logic [2:0]                DRAIN_LAST = 3'(READ_LATENCY);
    localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE   = 1;
    localparam logic [FAIL_CNT_WIDTH-1:0] CNT_ONE    = 1;

    state_e                state_q, state_d;
    elem_t                 elem_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  op_q;      // 0: first op at this address, 1: second
    logic [2:0]            drain_q;

    elem_info_t            cur;
    logic                  start_ok;
    logic                  is_read;
    logic                  op_last;
    logic                  addr_term;
    logic                  run_last;
    logic                  miscompare;
    logic [ADDR_WIDTH-1:0] miscompare_addr;

    assign cur       = elem_info(elem_q);
    assign start_ok  = start && (state_q == IDLE || state_q == DONE);
    assign is_read   = cur.has_read && !op_q;
    assign op_last   = !cur.two_ops || op_q;
    // Terminal count per sweep direction, so the address never carries out.
    assign addr_term = cur.down ? (addr_q == '0) : (addr_q == '1);
    assign run_last  = op_last && addr_term && (elem_q == E5);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)                   state_d = RUN;
            RUN:        if (run_last)                state_d = DRAIN;
            // RUN leaves with the last read READ_LATENCY edges from its data;
            // one more edge lets its compare land in fail_count before DONE.
            DRAIN:      if (drain_q == DRAIN_LAST)   state_d = DONE;
            default:                                 state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_q == RUN) || (state_q == DRAIN);
        done       = (state_q == DONE);
        state_dbg  = state_q;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (state_q == RUN) begin
            sram_addr = addr_q;
            if (!is_read) begin
                sram_we    = 1'b1;
                sram_wmask = '1;
                sram_din   = {DATA_WIDTH{cur.wr_bit}};
            end
        end
    end

    // Element / address / op / drain counters
    always_ff @(posedge clock) begin
        if (reset) begin
            elem_q  <= E0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            drain_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        elem_q  <= E0;
                        addr_q  <= '0;
                        op_q    <= 1'b0;
                        drain_q <= '0;
                    end
                end
                RUN: begin
                    drain_q <= '0;
                    if (!op_last) begin
                        op_q <= 1'b1;
                    end else begin
                        op_q <= 1'b0;
                        if (addr_term) begin
                            if (elem_q != E5) begin
                                elem_q <= elem_q + 3'd1;
                                addr_q <= elem_info(elem_q + 3'd1).down ? '1 : '0;
                            end
                        end else if (cur.down) begin
                            addr_q <= addr_q - ADDR_ONE;
                        end else begin
                            addr_q <= addr_q + ADDR_ONE;
                        end
                    end
                end
                DRAIN:   drain_q <= drain_q + 3'd1;
                default: drain_q <= '0;
            endcase
        end
    end

    sram_bist_cmp_pipe #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_cmp_pipe (
        .clock          (clock),
        .reset          (reset),
        .push_valid     ((state_q == RUN) && is_read),
        .push_addr      (addr_q),
        .push_data      ({DATA_WIDTH{cur.rd_bit}}),
        .dout           (sram_dout),
        .miscompare     (miscompare),
        .miscompare_addr(miscompare_addr)
    );

    // Result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
        end else if (start_ok) begin
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
        end else begin
            if (miscompare) begin
                // Zero count means no miscompare yet in this test.
                if (fail_count == '0) fail_addr <= miscompare_addr;
                if (fail_count != '1) fail_count <= fail_count + CNT_ONE;
            end
            if (state_q == DRAIN && drain_q == DRAIN_LAST)
                pass <= (fail_count == '0);
        end
    end

endmodule

// File: tb/tb_sram_bist_sky130.sv
module tb_sram_bist_sky130;
    import sram_bist_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int OPS   = 10 * DEPTH;
    localparam int DONE_EDGE = OPS + RL + 1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT (fault-injectable memory) ----------------
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [15:0]   fail_count;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    state_e        state_dbg;

    sram_bist_sky130 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW),
        .READ_LATENCY(RL), .FAIL_CNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_count(fail_count),
        .sram_we(sram_we), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout), .state_dbg(state_dbg)
    );

    // ---------------- second DUT: memory always reads all-ones ----------------
    logic          s_busy, s_done, s_pass;
    logic [AW-1:0] s_fail_addr;
    logic [1:0]    s_fail_count;
    logic          s_we;
    logic [MW-1:0] s_wmask;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    state_e        s_state_dbg;

    sram_bist_sky130 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW),
        .READ_LATENCY(RL), .FAIL_CNT_WIDTH(2)
    ) dut_sat (
        .clock(clock), .reset(reset), .start(start),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .fail_addr(s_fail_addr), .fail_count(s_fail_count),
        .sram_we(s_we), .sram_wmask(s_wmask),
        .sram_addr(s_addr), .sram_din(s_din),
        .sram_dout(32'hFFFF_FFFF), .state_dbg(s_state_dbg)
    );

    // ---------------- SRAM wrapper model: input register + macro read register ----------------
    logic          stuck_en = 1'b0;   // address 5, bit 3 stuck-at-0
    logic [DW-1:0] mem [DEPTH];
    logic          m_we = 1'b0;
    logic [MW-1:0] m_wmask = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;
    logic [DW-1:0] m_word;

    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    always @(posedge clock) begin
        m_we    <= sram_we;
        m_wmask <= sram_wmask;
        m_addr  <= sram_addr;
        m_din   <= sram_din;
    end

    always @(posedge clock) begin
        sram_dout <= mem[m_addr];
        if (m_we) begin
            m_word = mem[m_addr];
            for (int b = 0; b < MW; b++)
                if (m_wmask[b]) m_word[b*8 +: 8] = m_din[b*8 +: 8];
            if (stuck_en && m_addr == 4'd5) m_word[3] = 1'b0;
            mem[m_addr] <= m_word;
        end
    end

    // ---------------- scoreboard ----------------
    logic [40:0] exp_q[$];   // {we, wmask, addr, din} per operation
    logic [20:0] res_q[$];   // {pass, fail_addr, fail_count} per test
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_elem(input bit down, input bit do_rd, input bit rd_bit,
                             input bit do_wr, input bit wr_bit);
        logic [AW-1:0] a;
        for (int i = 0; i < DEPTH; i++) begin
            a = down ? AW'(DEPTH - 1 - i) : AW'(i);
            if (do_rd) exp_q.push_back({1'b0, 4'h0, a, 32'h0});
            if (do_wr) exp_q.push_back({1'b1, 4'hF, a, wr_bit ? 32'hFFFF_FFFF : 32'h0});
        end
    endtask

    task automatic push_march();
        push_elem(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // E0 up   w0
        push_elem(1'b0, 1'b1, 1'b0, 1'b1, 1'b1); // E1 up   r0 w1
        push_elem(1'b0, 1'b1, 1'b1, 1'b1, 1'b0); // E2 up   r1 w0
        push_elem(1'b1, 1'b1, 1'b0, 1'b1, 1'b1); // E3 down r0 w1
        push_elem(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // E4 down r1 w0
        push_elem(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // E5 up   r0
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_busy"},       64'(busy),       64'd0);
        check({pfx, "_done"},       64'(done),       64'd0);
        check({pfx, "_pass"},       64'(pass),       64'd0);
        check({pfx, "_fail_addr"},  64'(fail_addr),  64'd0);
        check({pfx, "_fail_count"}, 64'(fail_count), 64'd0);
        check({pfx, "_we"},         64'(sram_we),    64'd0);
        check({pfx, "_wmask"},      64'(sram_wmask), 64'd0);
        check({pfx, "_addr"},       64'(sram_addr),  64'd0);
        check({pfx, "_din"},        64'(sram_din),   64'd0);
    endtask

    // Runs one test from a start pulse. Edge 0 is the edge that samples start;
    // the loop samples outputs 1 time unit after each following edge.
    // inj_start > 0 : extra start sampled at that edge (while busy)
    // reset_at  > 0 : reset sampled at that edge, test abandoned
    task automatic run_test(input int inj_start, input int reset_at,
                            input logic exp_pass, input logic [AW-1:0] exp_faddr,
                            input logic [15:0] exp_fcnt);
        int e, done_edge, we_cnt;
        logic [40:0] exp_op;
        logic [20:0] exp_res;
        push_march();
        res_q.push_back({exp_pass, exp_faddr, exp_fcnt});
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        e         = 0;
        done_edge = -1;
        we_cnt    = 0;
        while (e < OPS + 100) begin
            if (reset_at > 0 && e == reset_at) begin
                check_reset_values("midreset");
                exp_q.delete();
                res_q.delete();
                reset = 1'b0;
                return;
            end
            if (e < OPS && exp_q.size() > 0) begin
                exp_op = exp_q.pop_front();
                check("op", {sram_we, sram_wmask, sram_addr, sram_din}, 64'(exp_op));
                if (sram_we) we_cnt++;
            end
            if (done) begin
                done_edge = e;
                break;
            end
            start = (inj_start > 0 && e == inj_start - 1);
            reset = (reset_at > 0 && e == reset_at - 1);
            @(posedge clock);
            #1;
            e++;
        end
        start = 1'b0;
        check("done_edge", 64'(done_edge), 64'(DONE_EDGE));
        check("ops_left", 64'(exp_q.size()), 64'd0);
        check("we_count", 64'(we_cnt), 64'(5 * DEPTH));
        exp_res = res_q.pop_front();
        check("result", 64'({pass, fail_addr, fail_count}), 64'(exp_res));
        @(posedge clock);
        #1;
        check("busy_after", 64'(busy), 64'd0);
        check("done_hold", 64'(done), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Fault-free memory
        run_test(0, 0, 1'b1, 4'd0, 16'd0);
        // Same run on the all-ones memory: counter saturates, first E1 read fails
        check("sat_done",       64'(s_done),       64'd1);
        check("sat_fail_count", 64'(s_fail_count), 64'd3);
        check("sat_fail_addr",  64'(s_fail_addr),  64'd0);
        check("sat_pass",       64'(s_pass),       64'd0);

        // Address 5 bit 3 stuck-at-0: E2 r1 and E4 r1 fail there
        stuck_en = 1'b1;
        run_test(0, 0, 1'b0, 4'd5, 16'd2);
        stuck_en = 1'b0;

        // Start while busy is ignored
        run_test(50, 0, 1'b1, 4'd0, 16'd0);

        // Reset mid-test, then a clean full run
        run_test(0, 70, 1'b1, 4'd0, 16'd0);
        repeat (2) @(posedge clock);
        run_test(0, 0, 1'b1, 4'd0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
